// File: rtl/vend_pkg.sv
// Shared types and constants for the newspaper vending controller.
//   state_e  : controller states
//   coin_e   : coin slot encodings
//   coin_value() maps a coin code to its value in won (0 for none/invalid)
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_BAD  = 2'b11
  } coin_e;

  localparam int VAL_5    = 5;
  localparam int VAL_10   = 10;
  localparam int CHG_UNIT = 5;

  function automatic logic [3:0] coin_value(input logic [1:0] c);
    logic [3:0] v;
    case (c)
      COIN_5:  v = 4'(VAL_5);
      COIN_10: v = 4'(VAL_10);
      default: v = 4'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Inactivity timer: clearable up-counter with a terminal-count flag.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   tc       : high while the count equals TIMEOUT-1
module vend_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

  // Saturate at terminal count so a stalled controller never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !tc)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vend_ctrl.sv
// Newspaper vending sequencing controller.
// Collects coins into a credit register, runs the dispenser handshake once
// credit reaches PRICE, then returns surplus one 5-won coin at a time.
//   clk          : system clock
//   rstn         : asynchronous reset, active-high
//   coin         : coin code sampled every cycle
//   cancel       : refund request
//   disp_ack     : dispenser released one item
//   chg_ack      : change unit released one 5-won coin
//   disp_req     : dispense request (held through DISPENSE)
//   chg_req      : change request (held through CHANGE)
//   credit       : current credit in won
//   busy         : DISPENSE or CHANGE
//   coin_reject  : coin sampled last cycle was not credited
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE   = 15,
  parameter int TIMEOUT = 1000,
  parameter int CRED_W  = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        coin,
  input  logic              cancel,
  input  logic              disp_ack,
  input  logic              chg_ack,
  output logic              disp_req,
  output logic              chg_req,
  output logic [CRED_W-1:0] credit,
  output logic              busy,
  output logic              coin_reject
);

  state_e            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic              disp_req_q, disp_req_d;
  logic              chg_req_q, chg_req_d;
  logic              busy_q, busy_d;
  logic              coin_reject_q, coin_reject_d;

  logic              coin_ok;
  logic              coin_any;
  logic [CRED_W-1:0] credit_sum;
  logic              tmr_tc;

  assign coin_ok    = (coin == COIN_5) || (coin == COIN_10);
  assign coin_any   = (coin != COIN_NONE);
  assign credit_sum = credit_q + CRED_W'(coin_value(coin));

  // Timer only runs in COLLECT; an accepted coin restarts the idle window,
  // an invalid coin does not.
  vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rstn),
    .clr ((state_q != COLLECT) || coin_ok),
    .en  (state_q == COLLECT),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_ok) begin
          credit_d = credit_sum;
          state_d  = (credit_sum >= CRED_W'(PRICE)) ? DISPENSE : COLLECT;
        end else if (coin == COIN_BAD) begin
          coin_reject_d = 1'b1;
        end
      end

      COLLECT: begin
        if (coin_ok) begin
          // Coin is credited before cancel is considered; a completed
          // purchase drops the cancel.
          credit_d = credit_sum;
          if (credit_sum >= CRED_W'(PRICE)) state_d = DISPENSE;
          else if (cancel)                   state_d = CHANGE;
        end else begin
          coin_reject_d = (coin == COIN_BAD);
          if (cancel || tmr_tc) state_d = CHANGE;
        end
      end

      DISPENSE: begin
        coin_reject_d = coin_any;
        if (disp_ack) begin
          credit_d = credit_q - CRED_W'(PRICE);
          state_d  = (credit_q > CRED_W'(PRICE)) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        coin_reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (chg_ack) begin
          credit_d = credit_q - CRED_W'(CHG_UNIT);
          if (credit_q == CRED_W'(CHG_UNIT)) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so they are registered with it.
    disp_req_d = (state_d == DISPENSE);
    chg_req_d  = (state_d == CHANGE);
    busy_d     = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      chg_req_q     <= chg_req_d;
      busy_q        <= busy_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign chg_req     = chg_req_q;
  assign credit      = credit_q;
  assign busy        = busy_q;
  assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: a transaction-level vending model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_vend_ctrl;

  localparam int PRICE = 15;
  localparam int TO    = 20;
  localparam int CW    = 6;

  localparam int M_IDLE = 0, M_COLL = 1, M_DISP = 2, M_CHG = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    coin = 2'b00;
  logic          cancel = 1'b0, disp_ack = 1'b0, chg_ack = 1'b0;
  logic          disp_req, chg_req, busy, coin_reject;
  logic [CW-1:0] credit;

  int checks = 0;
  int errors = 0;

  vend_ctrl #(.PRICE(PRICE), .TIMEOUT(TO), .CRED_W(CW)) dut (
    .clk         (clk),
    .rstn        (rst),
    .coin        (coin),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .chg_ack     (chg_ack),
    .disp_req    (disp_req),
    .chg_req     (chg_req),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what phase the sale is in, how much money is held,
  // and how long the customer has been idle.
  int m_ph = M_IDLE;
  int m_cr = 0;
  int m_idle = 0;
  bit m_rej = 1'b0;

  always @(posedge clk or posedge rst) begin
    int val;
    if (rst) begin
      m_ph = M_IDLE; m_cr = 0; m_idle = 0; m_rej = 1'b0;
    end else begin
      val   = (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
      m_rej = 1'b0;
      case (m_ph)
        M_IDLE: begin
          if (val > 0) begin
            m_cr += val; m_idle = 0;
            m_ph = (m_cr >= PRICE) ? M_DISP : M_COLL;
          end else if (coin == 2'b11) m_rej = 1'b1;
        end
        M_COLL: begin
          if (val > 0) begin
            m_cr += val; m_idle = 0;
            if (m_cr >= PRICE) m_ph = M_DISP;
            else if (cancel)   m_ph = M_CHG;
          end else begin
            if (coin == 2'b11) m_rej = 1'b1;
            if (cancel) m_ph = M_CHG;
            else if (m_idle == TO - 1) m_ph = M_CHG;
            else m_idle++;
          end
        end
        M_DISP: begin
          if (coin != 2'b00) m_rej = 1'b1;
          if (disp_ack) begin
            m_cr -= PRICE;
            m_ph = (m_cr > 0) ? M_CHG : M_IDLE;
          end
        end
        default: begin
          if (coin != 2'b00) m_rej = 1'b1;
          if (chg_ack && m_cr > 0) m_cr -= 5;
          if (m_cr == 0) m_ph = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("disp_req",    32'(disp_req),    32'(m_ph == M_DISP));
    chk("chg_req",     32'(chg_req),     32'(m_ph == M_CHG));
    chk("busy",        32'(busy),        32'(m_ph == M_DISP || m_ph == M_CHG));
    chk("credit",      32'(credit),      32'(m_cr));
    chk("coin_reject", 32'(coin_reject), 32'(m_rej));
  end

  task automatic tick(input logic [1:0] c, input logic cn = 1'b0,
                      input logic da = 1'b0, input logic ca = 1'b0);
    coin = c; cancel = cn; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_credit", 32'(credit), 0);
    chk("rst_outs",   {28'd0, disp_req, chg_req, busy, coin_reject}, 0);

    // Cancel and stray acks in IDLE do nothing.
    tick(2'b00, 1'b1, 1'b1, 1'b1);
    chk("idle_ignore_busy", 32'(busy), 0);
    chk("idle_ignore_cr",   32'(credit), 0);

    // 5-won coin held three cycles.
    tick(2'b01); chk("t1_cr5", 32'(credit), 5);
    tick(2'b01); chk("t1_cr10", 32'(credit), 10);
    tick(2'b01); chk("t1_cr15", 32'(credit), 15); chk("t1_dreq", 32'(disp_req), 1);
    tick(2'b00); chk("t1_hold", 32'(disp_req), 1);
    tick(2'b00, 1'b0, 1'b1); chk("t1_ack_cr", 32'(credit), 0);
    chk("t1_idle", {30'd0, disp_req, chg_req}, 0);

    // 5 then 10.
    tick(2'b01); tick(2'b10); chk("t2_cr15", 32'(credit), 15);
    tick(2'b00, 1'b0, 1'b1); chk("t2_busy", 32'(busy), 0);

    // 10 + 10 -> one coin of change.
    tick(2'b10); tick(2'b10); chk("t3_cr20", 32'(credit), 20);
    tick(2'b00, 1'b0, 1'b1); chk("t3_cr5", 32'(credit), 5); chk("t3_creq", 32'(chg_req), 1);
    tick(2'b00); chk("t3_wait", 32'(chg_req), 1);
    tick(2'b00, 1'b0, 1'b0, 1'b1); chk("t3_cr0", 32'(credit), 0); chk("t3_creq0", 32'(chg_req), 0);

    // 10 then cancel.
    tick(2'b10); tick(2'b00, 1'b1); chk("t4_creq", 32'(chg_req), 1); chk("t4_cr", 32'(credit), 10);
    tick(2'b00, 1'b0, 1'b0, 1'b1); chk("t4_cr5", 32'(credit), 5);
    tick(2'b00, 1'b0, 1'b0, 1'b1); chk("t4_cr0", 32'(credit), 0); chk("t4_busy", 32'(busy), 0);

    // Rejects in COLLECT and DISPENSE.
    tick(2'b01);
    tick(2'b11); chk("t5_rej_c", 32'(coin_reject), 1); chk("t5_cr", 32'(credit), 5);
    tick(2'b00); chk("t5_rej_off", 32'(coin_reject), 0);
    tick(2'b10); chk("t5_disp", 32'(disp_req), 1);
    tick(2'b01); chk("t5_rej_d", 32'(coin_reject), 1); chk("t5_cr15", 32'(credit), 15);
    tick(2'b00, 1'b0, 1'b1); chk("t5_done", 32'(credit), 0);

    // Cancel with a coin: completing coin wins, else refund full credit.
    tick(2'b01); tick(2'b10, 1'b1); chk("t6_disp", 32'(disp_req), 1);
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b01); tick(2'b01, 1'b1); chk("t6_chg", 32'(chg_req), 1); chk("t6_cr10", 32'(credit), 10);
    tick(2'b00, 1'b0, 1'b0, 1'b1); tick(2'b00, 1'b0, 1'b0, 1'b1);
    chk("t6_idle", 32'(busy), 0);

    // Inactivity timeout.
    tick(2'b01);
    for (int i = 0; i < TO - 1; i++) tick(2'b00);
    chk("t7_pre", 32'(chg_req), 0);
    tick(2'b00); chk("t7_chg", 32'(chg_req), 1); chk("t7_cr", 32'(credit), 5);
    tick(2'b00, 1'b0, 1'b0, 1'b1); chk("t7_done", 32'(credit), 0);

    // Asynchronous reset while disp_req is high.
    tick(2'b10); tick(2'b01); chk("t8_dreq", 32'(disp_req), 1);
    #3 rst = 1'b1;
    #1;
    chk("t8_async_dreq", 32'(disp_req), 0);
    chk("t8_async_cr",   32'(credit), 0);
    chk("t8_async_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2'b00); chk("t8_after", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
